seg7_scan_io: RTL
=================

Name: seg7_scan_io

Overview:
- Parametrised board-I/O front end that sits between the CPU and the board pins.
- Time-multiplexes an N-digit common-anode seven-segment display from a packed hex value, with per-digit enable and decimal points.
- Synchronises and debounces one push-button, producing a clean level plus a single-cycle press pulse for the CPU.
- Generalises the fixed 8-digit/single-button display path to any digit count, refresh rate and debounce time, with frame-coherent (tear-free) value updates.

Parameters:
- NUM_DIGITS, 8, number of digits driven; 1..16.
- REFRESH_DIV, 100000, clk cycles each digit stays lit; >=2.
- DEBOUNCE_CYCLES, 1000000, consecutive stable synced cycles required to accept a button change; >=2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- value  input  4*NUM_DIGITS  hex nibbles; nibble k = bits [4k+3:4k] = digit k (digit 0 rightmost).
- digit_en  input  NUM_DIGITS  1 = digit k lit; 0 = digit k blanked.
- dp_in  input  NUM_DIGITS  1 = decimal point of digit k on.
- btn_raw  input  1  asynchronous push-button (BTNC).
- AN  output  NUM_DIGITS  anode selects, active-low, one-hot-low or all-high.
- Seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point, active-low.
- btn_level  output  1  debounced button level.
- btn_pulse  output  1  one-cycle pulse on debounced 0->1.

Behaviour:
- Reset (rst=1 at an edge): AN all 1, Seg=7'h7F, DP=1, btn_level=0, btn_pulse=0, div_cnt=0, idx=0, shadow value/en/dp=0, sync flops=0, debounce count=0. Mid-operation reset has the same effect at the next edge; no partial frame completes.
- Divider: div_cnt counts 0..REFRESH_DIV-1, wraps to 0. On the terminal count, idx advances; idx wraps from NUM_DIGITS-1 to 0.
- Frame-coherent capture: shadow <= {value, digit_en, dp_in} on the first edge after reset release, and on every edge where idx wraps NUM_DIGITS-1 -> 0. Input changes mid-frame are not displayed until the next frame.
- Output stage, registered with 1-cycle latency from (idx, shadow):
  - AN = ~(1<<idx) when shadow_en[idx]=1, else all 1.
  - Seg = hex decode of shadow nibble idx.
  - DP = ~shadow_dp[idx].
  - A disabled digit also forces Seg=7'h7F and DP=1.
- Hex decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Button synchroniser: two flops. sync2 is the synchronised level.
- Debounce counter:
  - If sync2 == btn_level, count <= 0.
  - Otherwise count increments.
  - When count == DEBOUNCE_CYCLES-1 and sync2 still differs, btn_level <= sync2 and count <= 0.
  - A glitch shorter than DEBOUNCE_CYCLES never changes btn_level.
- btn_pulse = 1 for exactly the cycle after btn_level rises. No pulse on release.
- Widths: div_cnt and count are $clog2 of the parameter, minimum 1 bit. idx is $clog2(NUM_DIGITS), minimum 1 bit. No overflow is possible.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- When defined: at shadow capture, every digit above the most-significant nonzero nibble is treated as disabled (AN high, Seg 7'h7F) even if digit_en=1. Digit 0 is always shown, including when the value is 0.
- When not defined: digits display purely per digit_en.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, DEBOUNCE_CYCLES=8):
- Reset then value=16'h12AF, digit_en=4'hF, dp_in=0 -> AN cycles 1110, 1101, 1011, 0111, each held for 4 cycles. Seg cycles 0001110 (F), 0001000 (A), 0100100 (2), 1111001 (1). DP=1 throughout.
- digit_en=4'b0101, dp_in=4'b0001, value=16'h8888 -> AN=1110 with Seg=0000000 and DP=0. Slot for idx1 gives AN=1111, Seg=7F, DP=1. AN=1011 with Seg=0000000 and DP=1.
- value changed 16'h0000 -> 16'h1111 while idx=1 mid-frame -> digits 1-3 keep showing 0 (1000000) until idx wraps to 0. The next frame shows 1 (1111001) on all digits.
- btn_raw high for 5 cycles then low -> btn_level stays 0 and btn_pulse never asserts.
- btn_raw held high -> btn_level=1 exactly 2+8 cycles after the edge, btn_pulse high 1 cycle. Release held low -> btn_level=0 after 10 cycles, no pulse.
- rst asserted for 1 cycle mid-frame at idx=2 -> next cycle AN=1111, Seg=7F, btn_level=0. Scan restarts at idx0. With SEG7_LEADING_ZERO_BLANK_EN and value=16'h0030: AN shows only digits 0 and 1, and digit 0 shows 0 (1000000).

Source files
------------

// File: rtl/seg7_scan_io.sv
// seg7_scan_io
//   Board I/O front end between the CPU and the board pins.
//   - Scans an N-digit common-anode seven-segment display from a packed hex
//     value. Each digit has its own enable and decimal point. The value,
//     enables and decimal points are latched into a shadow copy once per
//     frame, so a frame never shows a mix of old and new data.
//   - Synchronises and debounces one push-button. It produces a clean level
//     and a one-cycle press pulse.
//
// Parameters
//   NUM_DIGITS       digits driven (1..16)
//   REFRESH_DIV      clk cycles each digit stays lit (>=2)
//   DEBOUNCE_CYCLES  consecutive stable synced cycles needed to accept a change (>=2)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   value      in   4*NUM_DIGITS  hex nibbles, nibble k = digit k (digit 0 rightmost)
//   digit_en   in   NUM_DIGITS    1 = digit lit
//   dp_in      in   NUM_DIGITS    1 = decimal point on
//   btn_raw    in   asynchronous push-button
//   AN         out  NUM_DIGITS    anode selects, active-low (one-hot-low or all-high)
//   Seg        out  7             segments {g,f,e,d,c,b,a}, active-low
//   DP         out  decimal point, active-low
//   btn_level  out  debounced button level
//   btn_pulse  out  one-cycle pulse on a debounced press
//
// Build option
//   SEG7_LEADING_ZERO_BLANK_EN  when defined, blanks every digit above the most
//                               significant nonzero nibble (digit 0 is never
//                               blanked by this rule).

module seg7_scan_io #(
    parameter int NUM_DIGITS      = 8,
    parameter int REFRESH_DIV     = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      btn_raw,
    output logic [NUM_DIGITS-1:0]     AN,
    output logic [6:0]                Seg,
    output logic                      DP,
    output logic                      btn_level,
    output logic                      btn_pulse
);

    localparam int DIV_W = ($clog2(REFRESH_DIV) < 1) ? 1 : $clog2(REFRESH_DIV);
    localparam int IDX_W = ($clog2(NUM_DIGITS) < 1) ? 1 : $clog2(NUM_DIGITS);
    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);

    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    // ------------------------------------------------------------------
    // Scan timing and frame-coherent shadow capture
    // ------------------------------------------------------------------
    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        idx;
    logic                    capture_pending;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_en;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   en_eff;
    logic                    div_tc;
    logic                    frame_wrap;

    assign div_tc     = (div_cnt == DIV_LAST);
    assign frame_wrap = div_tc && (idx == IDX_LAST);

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit. Once a nonzero nibble is seen, that digit
    // and every digit below it may be shown.
    always_comb begin
        logic seen_nonzero;
        en_eff       = digit_en;
        seen_nonzero = 1'b0;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            seen_nonzero = seen_nonzero | (value[4*k +: 4] != 4'h0);
            en_eff[k]    = digit_en[k] & seen_nonzero;
        end
    end
`else
    assign en_eff = digit_en;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt         <= '0;
            idx             <= '0;
            capture_pending <= 1'b1;
            shadow_val      <= '0;
            shadow_en       <= '0;
            shadow_dp       <= '0;
        end else begin
            div_cnt         <= div_tc ? '0 : div_cnt + DIV_W'(1);
            capture_pending <= 1'b0;
            if (div_tc)
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            // The first edge after reset fills the shadow so the first frame
            // shows real data rather than waiting a whole frame.
            if (capture_pending || frame_wrap) begin
                shadow_val <= value;
                shadow_en  <= en_eff;
                shadow_dp  <= dp_in;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output stage: registered, one cycle behind (idx, shadow)
    // ------------------------------------------------------------------
    logic [3:0] cur_nib;
    logic       cur_en;
    logic       cur_dp;
    logic [6:0] seg_dec;

    always_comb begin
        cur_nib = shadow_val[4*int'(idx) +: 4];
        cur_en  = shadow_en[idx];
        cur_dp  = shadow_dp[idx];
    end

    always_comb begin
        seg_dec = 7'h7F;
        case (cur_nib)
            4'h0: seg_dec = 7'b1000000;
            4'h1: seg_dec = 7'b1111001;
            4'h2: seg_dec = 7'b0100100;
            4'h3: seg_dec = 7'b0110000;
            4'h4: seg_dec = 7'b0011001;
            4'h5: seg_dec = 7'b0010010;
            4'h6: seg_dec = 7'b0000010;
            4'h7: seg_dec = 7'b1111000;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0010000;
            4'hA: seg_dec = 7'b0001000;
            4'hB: seg_dec = 7'b0000011;
            4'hC: seg_dec = 7'b1000110;
            4'hD: seg_dec = 7'b0100001;
            4'hE: seg_dec = 7'b0000110;
            4'hF: seg_dec = 7'b0001110;
            default: seg_dec = 7'h7F;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            AN  <= '1;
            Seg <= 7'h7F;
            DP  <= 1'b1;
        end else if (cur_en) begin
            AN  <= ~(ONE_HOT0 << idx);
            Seg <= seg_dec;
            DP  <= ~cur_dp;
        end else begin
            AN  <= '1;
            Seg <= 7'h7F;
            DP  <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Button synchroniser and debounce
    // ------------------------------------------------------------------
    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] deb_cnt;

    // deb_cnt is the length of the current run of synced samples that
    // disagree with btn_level. Any agreeing sample restarts the run.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            deb_cnt   <= '0;
            btn_level <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            sync1     <= btn_raw;
            sync2     <= sync1;
            btn_pulse <= 1'b0;
            if (sync2 == btn_level) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                btn_level <= sync2;
                btn_pulse <= sync2;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

endmodule
